// File: rtl/ysyx_22040931_ifu_pkg.sv
// Shared types and constants for the ysyx_22040931 fetch unit.
// Holds the FSM state encoding, instruction width and default reset PC.
package ysyx_22040931_ifu_pkg;

  localparam int          INST_W       = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22040931_ifu_pcreg.sv
// Program counter register: async active-low reset to RESET_PC, loads d_i when ld_i.
// Single-cycle update, no handshake.
module ysyx_22040931_PcReg #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_i,
  input  logic [ADDR_W-1:0] d_i,
  output logic [ADDR_W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= RESET_PC;
    end else if (ld_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ysyx_22040931_ifu.sv
// Fetch unit: one outstanding imem fetch, registered instr/pc towards decode with redirect support.
// Accept at t, response at t+k, out_valid at t+k+1; held stable while out_ready is low.
module ysyx_22040931_ifu
  import ysyx_22040931_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  ifu_state_e        state_q, state_d;
  logic              live_q;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              out_valid_q, out_valid_d;
  logic [INST_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_ld;
  logic [ADDR_W-1:0] redir_tgt;
  logic              req_fire;

  assign redir_tgt = redirect_pc & ~ADDR_W'(3);

  // live_q keeps the request low in the reset cycle even though the state is already REQ.
  assign imem_req_valid = live_q && (state_q == IFU_REQ);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;

  ysyx_22040931_PcReg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_i  (pc_ld),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    pend_pc_d   = pend_pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    pc_ld       = 1'b0;
    pc_d        = pc_q + ADDR_W'(4);
    case (state_q)
      IFU_REQ: begin
        if (redirect_valid) begin
          pend_pc_d = redir_tgt;
          drop_d    = 1'b1;
        end
        if (req_fire) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          if (!drop_q && !redirect_valid) begin
            out_instr_d = imem_rsp_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            state_d     = IFU_HOLD;
          end else begin
            // A same-cycle redirect is newer than anything already pending.
            pc_ld   = 1'b1;
            pc_d    = redirect_valid ? redir_tgt : pend_pc_q;
            drop_d  = 1'b0;
            state_d = IFU_REQ;
          end
        end else if (redirect_valid) begin
          pend_pc_d = redir_tgt;
          drop_d    = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pc_ld       = 1'b1;
          pc_d        = redirect_valid ? redir_tgt : pc_q + ADDR_W'(4);
          state_d     = IFU_REQ;
        end else if (redirect_valid) begin
          out_valid_d = 1'b0;
          pc_ld       = 1'b1;
          pc_d        = redir_tgt;
          state_d     = IFU_REQ;
        end
      end
      default: state_d = IFU_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IFU_REQ;
      live_q      <= 1'b0;
      drop_q      <= 1'b0;
      pend_pc_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      drop_q      <= drop_d;
      pend_pc_q   <= pend_pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// Directed bench for ysyx_22040931_ifu with a latency-configurable memory model and
// scoreboards of expected request addresses and expected decode-side outputs.
module tb_ysyx_22040931_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  ysyx_22040931_ifu #(
    .ADDR_W   (64),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_tot  = 0;
  int          cyc    = 0;
  int          prev_hs = -1;
  bit          tput_on = 0;
  bit          force_rsp = 0;
  bit          acc_seen = 0;
  int          mem_lat = 1;
  int          req_budget = 0;
  bit          busy = 0;
  int          cnt = 0;
  logic [63:0] maddr = '0;
  logic        last_req_vld = 1'b0;
  logic [63:0] last_req_addr = '0;
  logic        last_out_vld = 1'b0;
  logic [63:0] last_out_pc = '0;
  logic [31:0] last_out_instr = '0;
  logic [63:0] exp_req_q[$];
  logic [63:0] exp_out_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_fetch(input logic [63:0] addr, input bit deliver);
    exp_req_q.push_back(addr);
    req_budget++;
    if (deliver) exp_out_q.push_back(addr);
  endtask

  // One clock: observe what happened at the edge, then drive the memory side for the next one.
  task automatic step();
    bit          acc, hs;
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    acc = rst_n && last_req_vld && imem_req_ready;
    hs  = rst_n && last_out_vld && out_ready;
    if (!rst_n) busy = 0;
    if (acc) begin
      req_budget--;
      if (exp_req_q.size() != 0) e = exp_req_q.pop_front();
      else e = 'x;
      chk("req_addr", last_req_addr, e);
      busy  = 1;
      cnt   = mem_lat;
      maddr = last_req_addr;
    end
    if (hs) begin
      if (exp_out_q.size() != 0) e = exp_out_q.pop_front();
      else e = 'x;
      chk("out_pc", last_out_pc, e);
      chk("out_instr", {32'b0, last_out_instr}, {32'b0, e[31:0] ^ 32'h13});
      if (tput_on && prev_hs >= 0) chk("throughput", 64'(cyc - prev_hs), 64'd3);
      prev_hs = cyc;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = maddr[31:0] ^ 32'h13;
        busy = 0;
      end
    end
    if (force_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    last_req_vld   = imem_req_valid;
    last_req_addr  = imem_req_addr;
    last_out_vld   = out_valid;
    last_out_pc    = out_pc;
    last_out_instr = out_instr;
    imem_req_ready = (req_budget > 0);
    acc_seen       = acc;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_req_q.size() + exp_out_q.size()) != 0 && n < max) begin
      step();
      n++;
    end
    repeat (3) step();
    chk(tag, 64'(exp_req_q.size() + exp_out_q.size()), 64'd0);
  endtask

  task automatic wait_out_vld(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      step();
      n++;
    end
    chk("wait_out_valid", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic wait_acc(input int max);
    int n = 0;
    acc_seen = 0;
    while (!acc_seen && n < max) begin
      step();
      n++;
    end
    chk("wait_accept", {63'b0, acc_seen}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) step();
    chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'b0, out_instr}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);

    // Reset fetch, zero-wait memory, out_ready high.
    rst_n   = 1'b1;
    tput_on = 1;
    expect_fetch(64'h8000_0000, 1);
    expect_fetch(64'h8000_0004, 1);
    expect_fetch(64'h8000_0008, 1);
    step();
    chk("first_req_valid", {63'b0, imem_req_valid}, 64'd1);
    chk("first_req_addr", imem_req_addr, 64'h8000_0000);
    drain("drain_reset_fetch", 40);
    tput_on = 0;

    // Backpressure for 5 cycles in HOLD.
    out_ready = 1'b0;
    expect_fetch(64'h8000_000C, 1);
    wait_out_vld(20);
    repeat (5) begin
      step();
      chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_out_pc", out_pc, 64'h8000_000C);
      chk("bp_out_instr", {32'b0, out_instr}, 64'h8000_001F);
      chk("bp_no_req", {63'b0, imem_req_valid}, 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_next_addr", imem_req_addr, 64'h8000_0010);
    chk("bp_next_valid", {63'b0, imem_req_valid}, 64'd1);
    expect_fetch(64'h8000_0010, 1);
    drain("drain_backpressure", 40);

    // Redirect in WAIT with a 3-cycle response pending; target has low bits set.
    mem_lat = 3;
    expect_fetch(64'h8000_0014, 0);
    wait_acc(20);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    step();
    redirect_valid = 1'b0;
    mem_lat = 1;
    expect_fetch(64'h8000_1000, 1);
    drain("drain_redirect_wait", 40);

    // Redirect in REQ while the memory refuses the request for 4 cycles.
    chk("rq_addr_before", imem_req_addr, 64'h8000_1004);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    repeat (4) begin
      step();
      chk("rq_addr_stable", imem_req_addr, 64'h8000_1004);
      chk("rq_valid_held", {63'b0, imem_req_valid}, 64'd1);
    end
    expect_fetch(64'h8000_1004, 0);
    expect_fetch(64'h8000_2000, 1);
    drain("drain_redirect_req", 40);

    // Consume and redirect in the same HOLD cycle.
    out_ready = 1'b0;
    expect_fetch(64'h8000_2004, 1);
    wait_out_vld(20);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("hold_redir_addr", imem_req_addr, 64'h8000_0100);
    expect_fetch(64'h8000_0100, 1);
    drain("drain_hold_redirect", 40);

    // Async reset in WAIT, then a stale response after release.
    mem_lat = 3;
    expect_fetch(64'h8000_0104, 0);
    wait_acc(20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    busy = 0;
    req_budget = 0;
    repeat (2) step();
    chk("arst_out_pc", out_pc, 64'd0);
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    force_rsp      = 1;
    mem_lat        = 1;
    expect_fetch(64'h8000_0000, 1);
    step();
    force_rsp = 0;
    chk("arst_restart_addr", imem_req_addr, 64'h8000_0000);
    drain("drain_after_reset", 40);

    // Wrap from the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    expect_fetch(64'h8000_0004, 0);
    expect_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1);
    expect_fetch(64'h0, 1);
    drain("drain_wrap", 60);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
